// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing controller for a radix-2 Booth multiplier datapath.
//
// Drives the datapath control strobes that load M and Q, add or subtract M
// into A, shift A:Q:Q[-1] right arithmetically, and put A then Q on the output
// bus. All outputs are decoded from the registered state.
//
// Ports
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   start : begin a multiply (looked at only in IDLE)
//   q0    : Q[0] from the Q register (looked at only in CHECK)
//   q_m1  : Q[-1] from the Q register (looked at only in CHECK)
//   c0    : clear A and Q[-1], load M from ibus
//   c1    : load Q from ibus
//   c3    : A <= A +/- M
//   sub   : with c3, 1 = subtract, 0 = add
//   c4    : arithmetic right shift of A:Q:Q[-1]
//   c5    : drive A onto obus
//   c6    : drive Q onto obus
//   busy  : high in every state except IDLE
//   done  : one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_M | clear A/Q[-1], load M, clear iteration count
// LOAD_Q | load Q
// CHECK  | inspect {Q[0],Q[-1]}, pick add/sub/no-op
// ADDSUB | A <= A +/- M
// SHIFT  | shift A:Q:Q[-1], advance iteration count
// OUT_A  | A onto obus
// OUT_Q  | Q onto obus
// DONE   | completion pulse

module booth_ctrl #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q0,
    input  logic q_m1,
    output logic c0,
    output logic c1,
    output logic c3,
    output logic sub,
    output logic c4,
    output logic c5,
    output logic c6,
    output logic busy,
    output logic done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_M = 4'd1,
        LOAD_Q = 4'd2,
        CHECK  = 4'd3,
        ADDSUB = 4'd4,
        SHIFT  = 4'd5,
        OUT_A  = 4'd6,
        OUT_Q  = 4'd7,
        DONE   = 4'd8
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic            sub_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Holds at N-1 on the last shift so it never wraps within an operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == LOAD_M) begin
            cnt <= '0;
        end else if (state == SHIFT && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Captured in CHECK so that Q bits moving during ADDSUB cannot flip the op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_r <= 1'b0;
        end else if (state == CHECK) begin
            sub_r <= q0 & ~q_m1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD_M;
            LOAD_M:  state_nx = LOAD_Q;
            LOAD_Q:  state_nx = CHECK;
            CHECK: begin
                case ({q0, q_m1})
                    2'b10, 2'b01: state_nx = ADDSUB;
                    default:      state_nx = SHIFT;
                endcase
            end
            ADDSUB:  state_nx = SHIFT;
            SHIFT:   state_nx = (cnt == LAST) ? OUT_A : CHECK;
            OUT_A:   state_nx = OUT_Q;
            OUT_Q:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        c0   = 1'b0;
        c1   = 1'b0;
        c3   = 1'b0;
        sub  = 1'b0;
        c4   = 1'b0;
        c5   = 1'b0;
        c6   = 1'b0;
        done = 1'b0;
        busy = (state != IDLE);
        case (state)
            LOAD_M: c0 = 1'b1;
            LOAD_Q: c1 = 1'b1;
            ADDSUB: begin
                c3  = 1'b1;
                sub = sub_r;
            end
            SHIFT:  c4 = 1'b1;
            OUT_A:  c5 = 1'b1;
            OUT_Q:  c6 = 1'b1;
            DONE:   done = 1'b1;
            default: ;
        endcase
    end

endmodule
